// File: rtl/tvf_writeback_packer_pkg.sv
// Shared sizing helpers and {t, v, f} entry field offsets for the writeback packer
// and the matching T-reload unpacker.
package tvf_writeback_packer_pkg;

  localparam int T_BITS_DEF     = 2;
  localparam int VEF_BITS_DEF   = 12;
  localparam int SRAM_WORD_DEF  = 104;
  localparam int FIFO_DEPTH_DEF = 2;

  localparam int F_LSB = 0;

  function automatic int entry_width(input int t_bits, input int vef_bits);
    return t_bits + 2 * vef_bits;
  endfunction

  function automatic int entries_per_word(input int word_bits, input int entry_w);
    return word_bits / entry_w;
  endfunction

  function automatic int v_lsb(input int vef_bits);
    return vef_bits;
  endfunction

  function automatic int t_lsb(input int vef_bits);
    return 2 * vef_bits;
  endfunction

endpackage

// File: rtl/tvf_writeback_packer_fifo.sv
// Small synchronous FIFO for completed SRAM words; head is read combinationally.
module sync_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the consumer gates the head with empty.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/tvf_writeback_packer.sv
// Packs (t, v, f) entries into SRAM words, queues completed words and streams them
// out; a partial word is zero-padded and flushed when the pass ends.
module tvf_writeback_packer
  import tvf_writeback_packer_pkg::*;
#(
  parameter int T_BITS     = T_BITS_DEF,
  parameter int VEF_BITS   = VEF_BITS_DEF,
  parameter int SRAM_WORD  = SRAM_WORD_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [T_BITS-1:0]    i_t,
  input  logic [VEF_BITS-1:0]  i_v,
  input  logic [VEF_BITS-1:0]  i_f,
  input  logic                 i_last,
  output logic                 o_send,
  input  logic                 i_send_ready,
  output logic [SRAM_WORD-1:0] o_send_data,
  output logic                 o_send_last,
  output logic                 o_done
);

  localparam int ENTRY_W = entry_width(T_BITS, VEF_BITS);
  localparam int EPW     = entries_per_word(SRAM_WORD, ENTRY_W);
  localparam int SLOT_W  = (EPW > 1) ? $clog2(EPW) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  generate
    if (EPW == 0) begin : g_bad_epw
      $error("tvf_writeback_packer: SRAM_WORD too narrow for one entry");
    end
  endgenerate

  logic [SLOT_W-1:0]    slot;
  logic [SRAM_WORD-1:0] asm_word;
  logic [SRAM_WORD-1:0] next_word;
  logic [ENTRY_W-1:0]   entry;
  logic                 accept, word_done, push, pop;
  logic                 fifo_full, fifo_empty;
  logic [SRAM_WORD:0]   fifo_head;
  logic [CNT_W-1:0]     fifo_count;

  always_comb begin
    entry = '0;
    entry[F_LSB +: VEF_BITS]            = i_f;
    entry[v_lsb(VEF_BITS) +: VEF_BITS]  = i_v;
    entry[t_lsb(VEF_BITS) +: T_BITS]    = i_t;
  end

  always_comb begin
    next_word = asm_word;
    for (int k = 0; k < EPW; k++) begin
      if (slot == SLOT_W'(k)) next_word[k*ENTRY_W +: ENTRY_W] = entry;
    end
  end

  assign o_ready   = !fifo_full;
  assign accept    = i_valid & o_ready;
  assign word_done = (slot == SLOT_W'(EPW - 1)) | i_last;
  assign push      = accept & word_done & !i_clear;
  assign pop       = o_send & i_send_ready & !i_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot     <= '0;
      asm_word <= '0;
      o_done   <= 1'b0;
    end else if (i_clear) begin
      slot     <= '0;
      asm_word <= '0;
      o_done   <= 1'b0;
    end else begin
      o_done <= pop & fifo_head[SRAM_WORD];
      if (accept) begin
        if (word_done) begin
          slot     <= '0;
          asm_word <= '0;
        end else begin
          slot     <= slot + 1'b1;
          asm_word <= next_word;
        end
      end
    end
  end

  sync_word_fifo #(
    .WIDTH (SRAM_WORD + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (i_clear),
    .push      (push),
    .push_data ({i_last, next_word}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign o_send      = !fifo_empty;
  assign o_send_last = fifo_empty ? 1'b0 : fifo_head[SRAM_WORD];
  assign o_send_data = fifo_empty ? '0 : fifo_head[SRAM_WORD-1:0];

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_tvf_writeback_packer.sv
// Directed bench for tvf_writeback_packer at default parameters (26-bit entries, 4 per word).
module tb_tvf_writeback_packer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_clear = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [1:0]   i_t = '0;
  logic [11:0]  i_v = '0;
  logic [11:0]  i_f = '0;
  logic         i_last = 1'b0;
  logic         o_send;
  logic         i_send_ready = 1'b0;
  logic [103:0] o_send_data;
  logic         o_send_last;
  logic         o_done;

  tvf_writeback_packer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (i_clear),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_t          (i_t),
    .i_v          (i_v),
    .i_f          (i_f),
    .i_last       (i_last),
    .o_send       (o_send),
    .i_send_ready (i_send_ready),
    .o_send_data  (o_send_data),
    .o_send_last  (o_send_last),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_xfer_cyc = -1;
  logic [104:0] wq[$];

  // Captures every transferred word as {last, data} and every o_done pulse.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_n && !i_clear && o_send && i_send_ready) begin
      wq.push_back({o_send_last, o_send_data});
      if (o_send_last) last_xfer_cyc = cyc;
    end
    if (o_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [25:0] ent(input int idx);
    logic [1:0]  t;
    logic [11:0] v;
    logic [11:0] f;
    t = idx[1:0];
    v = idx[11:0];
    f = 12'(idx + 8);
    return {t, v, f};
  endfunction

  function automatic logic [103:0] pack(input int base, input int n);
    logic [103:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[k*26 +: 26] = ent(base + k);
    return w;
  endfunction

  task automatic send(input int idx, input bit last);
    bit acc;
    acc = 1'b0;
    i_valid = 1'b1;
    {i_t, i_v, i_f} = ent(idx);
    i_last = last;
    for (int w = 0; w < 50 && !acc; w++) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      total_cnt++;
      $display("FAIL send_timeout entry=%0d not accepted within 50 cycles", idx);
    end
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    total_cnt++;
    if (o_send !== 1'b0) $display("FAIL reset_send got=%b want=0", o_send); else pass_cnt++;
    total_cnt++;
    if (o_ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", o_ready); else pass_cnt++;
    total_cnt++;
    if (o_done !== 1'b0) $display("FAIL reset_done got=%b want=0", o_done); else pass_cnt++;
    total_cnt++;
    if (o_send_data !== 104'd0 || o_send_last !== 1'b0)
      $display("FAIL reset_data got=%h/%b want=0/0", o_send_data, o_send_last);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    bit ready_ok;
    wq.delete();
    i_send_ready = 1'b1;
    ready_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(k, 1'b0);
      if (o_ready !== 1'b1) ready_ok = 1'b0;
    end
    total_cnt++;
    if (o_send !== 1'b1 || o_send_data !== pack(0, 4))
      $display("FAIL basic_latency got=%b/%h want=1/%h", o_send, o_send_data, pack(0, 4));
    else pass_cnt++;
    total_cnt++;
    if (o_send_last !== 1'b0) $display("FAIL basic_last got=%b want=0", o_send_last); else pass_cnt++;
    total_cnt++;
    if (!ready_ok) $display("FAIL basic_ready got=0 want=1"); else pass_cnt++;
    idle(3);
    total_cnt++;
    if (wq.size() != 1) $display("FAIL basic_count got=%0d want=1", wq.size()); else pass_cnt++;
  endtask

  task automatic test_last;
    wq.delete();
    done_cnt = 0;
    for (int k = 1; k <= 6; k++) send(k, k == 6);
    idle(4);
    total_cnt++;
    if (wq.size() != 2) $display("FAIL last_count got=%0d want=2", wq.size()); else pass_cnt++;
    if (wq.size() == 2) begin
      total_cnt++;
      if (wq[0] !== {1'b0, pack(1, 4)})
        $display("FAIL last_word1 got=%h want=%h", wq[0], {1'b0, pack(1, 4)});
      else pass_cnt++;
      total_cnt++;
      if (wq[1] !== {1'b1, pack(5, 2)})
        $display("FAIL last_word2 got=%h want=%h", wq[1], {1'b1, pack(5, 2)});
      else pass_cnt++;
    end
    total_cnt++;
    if (done_cnt != 1) $display("FAIL last_done_count got=%0d want=1", done_cnt); else pass_cnt++;
    total_cnt++;
    if (done_cyc != last_xfer_cyc + 1)
      $display("FAIL last_done_timing got=%0d want=%0d", done_cyc, last_xfer_cyc + 1);
    else pass_cnt++;
  endtask

  task automatic test_stall;
    logic [103:0] hold;
    bit stable;
    wq.delete();
    i_send_ready = 1'b0;
    for (int k = 10; k < 18; k++) send(k, 1'b0);
    total_cnt++;
    if (o_ready !== 1'b0 || o_send !== 1'b1)
      $display("FAIL stall_full got=ready %b send %b want=ready 0 send 1", o_ready, o_send);
    else pass_cnt++;
    hold = o_send_data;
    total_cnt++;
    if (hold !== pack(10, 4)) $display("FAIL stall_head got=%h want=%h", hold, pack(10, 4)); else pass_cnt++;
    i_valid = 1'b1;
    {i_t, i_v, i_f} = ent(18);
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (o_send_data !== hold || o_ready !== 1'b0) stable = 1'b0;
    end
    total_cnt++;
    if (!stable) $display("FAIL stall_stable got=changed want=held"); else pass_cnt++;
    total_cnt++;
    if (wq.size() != 0) $display("FAIL stall_no_xfer got=%0d want=0", wq.size()); else pass_cnt++;
    @(posedge clk);
    #1;
    i_send_ready = 1'b1;
    for (int k = 18; k < 22; k++) send(k, 1'b0);
    idle(6);
    total_cnt++;
    if (wq.size() != 3) $display("FAIL stall_count got=%0d want=3", wq.size()); else pass_cnt++;
    for (int i = 0; i < 3 && i < wq.size(); i++) begin
      total_cnt++;
      if (wq[i] !== {1'b0, pack(10 + 4*i, 4)})
        $display("FAIL stall_word%0d got=%h want=%h", i, wq[i], {1'b0, pack(10 + 4*i, 4)});
      else pass_cnt++;
    end
  endtask

  task automatic test_last_slot3;
    wq.delete();
    done_cnt = 0;
    i_send_ready = 1'b1;
    i_valid = 1'b0;
    i_last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_last = 1'b0;
    total_cnt++;
    if (wq.size() != 0 || done_cnt != 0 || o_send !== 1'b0)
      $display("FAIL idle_last got=%0d words %0d done want=0/0", wq.size(), done_cnt);
    else pass_cnt++;
    for (int k = 30; k < 34; k++) send(k, k == 33);
    idle(5);
    total_cnt++;
    if (wq.size() != 1) $display("FAIL slot3_count got=%0d want=1", wq.size()); else pass_cnt++;
    if (wq.size() >= 1) begin
      total_cnt++;
      if (wq[0] !== {1'b1, pack(30, 4)})
        $display("FAIL slot3_word got=%h want=%h", wq[0], {1'b1, pack(30, 4)});
      else pass_cnt++;
    end
    total_cnt++;
    if (done_cnt != 1) $display("FAIL slot3_done got=%0d want=1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int start_cyc;
    int elapsed;
    wq.delete();
    i_send_ready = 1'b0;
    for (int k = 40; k < 48; k++) send(k, 1'b0);
    i_send_ready = 1'b1;
    start_cyc = cyc;
    for (int k = 48; k < 64; k++) send(k, 1'b0);
    elapsed = cyc - start_cyc;
    idle(6);
    total_cnt++;
    if (elapsed != 17) $display("FAIL b2b_cycles got=%0d want=17", elapsed); else pass_cnt++;
    total_cnt++;
    if (wq.size() != 6) $display("FAIL b2b_count got=%0d want=6", wq.size()); else pass_cnt++;
    for (int i = 0; i < 6 && i < wq.size(); i++) begin
      total_cnt++;
      if (wq[i] !== {1'b0, pack(40 + 4*i, 4)})
        $display("FAIL b2b_word%0d got=%h want=%h", i, wq[i], {1'b0, pack(40 + 4*i, 4)});
      else pass_cnt++;
    end
  endtask

  task automatic test_clear;
    wq.delete();
    i_send_ready = 1'b0;
    for (int k = 70; k < 76; k++) send(k, 1'b0);
    i_clear = 1'b1;
    i_valid = 1'b1;
    {i_t, i_v, i_f} = ent(76);
    @(posedge clk);
    #1;
    i_clear = 1'b0;
    i_valid = 1'b0;
    total_cnt++;
    if (o_send !== 1'b0 || o_ready !== 1'b1 || o_done !== 1'b0)
      $display("FAIL clear_state got=send %b ready %b done %b want=0 1 0", o_send, o_ready, o_done);
    else pass_cnt++;
    i_send_ready = 1'b1;
    for (int k = 80; k < 84; k++) send(k, 1'b0);
    idle(4);
    total_cnt++;
    if (wq.size() != 1 || wq[0] !== {1'b0, pack(80, 4)})
      $display("FAIL clear_fresh got=%0d words first %h want=1 %h", wq.size(),
               (wq.size() > 0) ? wq[0] : 105'd0, {1'b0, pack(80, 4)});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    wq.delete();
    i_send_ready = 1'b0;
    for (int k = 90; k < 96; k++) send(k, 1'b0);
    i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (o_send !== 1'b0 || o_ready !== 1'b1 || o_send_data !== 104'd0)
      $display("FAIL async_reset got=send %b ready %b data %h want=0 1 0", o_send, o_ready, o_send_data);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    i_send_ready = 1'b1;
    for (int k = 100; k < 104; k++) send(k, 1'b0);
    idle(4);
    total_cnt++;
    if (wq.size() != 1 || wq[0] !== {1'b0, pack(100, 4)})
      $display("FAIL reset_fresh got=%0d words first %h want=1 %h", wq.size(),
               (wq.size() > 0) ? wq[0] : 105'd0, {1'b0, pack(100, 4)});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_last();
    test_stall();
    test_last_slot3();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
